// File: rtl/exp2_fixed_point_pkg.sv
// Shared widths and types for the fixed-point 2^x antilog pipeline.
// INT_W must equal clog2(WORD_W) so the integer part spans every legal shift.
package exp2_fixed_point_pkg;
    localparam int WORD_W = 8;
    localparam int FRAC_W = 8;
    localparam int INT_W  = 3;
    localparam int ACC_W  = FRAC_W + WORD_W + 1;

    typedef logic [INT_W+FRAC_W-1:0] log_t;
    typedef logic [ACC_W-1:0]        acc_t;
    typedef logic [INT_W-1:0]        sh_t;
    typedef logic [WORD_W-1:0]       word_t;

    // Mitchell mantissa: 2^f is approximated by 1+f, placed at the bottom of the accumulator.
    function automatic acc_t mitchell_mant(input logic [FRAC_W-1:0] frac);
        return {{(ACC_W-FRAC_W-1){1'b0}}, 1'b1, frac};
    endfunction
endpackage

// File: rtl/exp2_shift_stage.sv
// One registered conditional left-shift stage of the antilog barrel shifter.
// Shifts the accumulator by SHIFT when i_sh[SEL_BIT] is set; everything holds while i_adv is low.
module exp2_shift_stage
    import exp2_fixed_point_pkg::*;
#(
    parameter int SHIFT   = 1,
    parameter int SEL_BIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_adv,
    input  logic i_valid,
    input  logic i_zero,
    input  sh_t  i_sh,
    input  acc_t i_acc,
    output logic o_valid,
    output logic o_zero,
    output sh_t  o_sh,
    output acc_t o_acc
);
    logic r_valid;
    logic r_zero;
    sh_t  r_sh;
    acc_t r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_sh    <= '0;
            r_acc   <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_zero  <= i_zero;
            r_sh    <= i_sh;
            r_acc   <= i_sh[SEL_BIT] ? (i_acc << SHIFT) : i_acc;
        end
    end

    assign o_valid = r_valid;
    assign o_zero  = r_zero;
    assign o_sh    = r_sh;
    assign o_acc   = r_acc;
endmodule

// File: rtl/exp2_fixed_point_pipe.sv
// Fixed-point antilog 2^x: Mitchell mantissa, staged barrel left-shift by the integer part,
// then round half-up and saturate to WORD_W bits. Five register stages, one sample per cycle.
module exp2_fixed_point_pipe
    import exp2_fixed_point_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        i_VALID,
    output logic        o_READY,
    input  log_t        i_LOG,
    input  logic        i_ZERO,
    output logic        o_VALID,
    input  logic        i_READY,
    output word_t       o_WORD,
    output logic        o_SAT
);
    // Handshake: a transfer happens only on an enabled edge where valid and ready are both high.
    // The whole pipe moves as one: it advances when enabled and the output slot is empty or being
    // taken; otherwise every stage holds, so o_READY is exactly that advance condition.
    logic w_adv;
    logic r_out_valid;

    assign w_adv   = enb & (~r_out_valid | i_READY);
    assign o_READY = w_adv;

    logic r_s0_valid;
    logic r_s0_zero;
    sh_t  r_s0_sh;
    acc_t r_s0_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_zero  <= 1'b0;
            r_s0_sh    <= '0;
            r_s0_acc   <= '0;
        end else if (w_adv) begin
            r_s0_valid <= i_VALID;
            r_s0_zero  <= i_ZERO;
            r_s0_sh    <= i_LOG[INT_W+FRAC_W-1:FRAC_W];
            r_s0_acc   <= mitchell_mant(i_LOG[FRAC_W-1:0]);
        end
    end

    logic w_valid [0:INT_W];
    logic w_zero  [0:INT_W];
    sh_t  w_sh    [0:INT_W];
    acc_t w_acc   [0:INT_W];

    assign w_valid[0] = r_s0_valid;
    assign w_zero[0]  = r_s0_zero;
    assign w_sh[0]    = r_s0_sh;
    assign w_acc[0]   = r_s0_acc;

    // Largest shift first, mirroring the CLZ normalise chain in reverse.
    for (genvar g = 0; g < INT_W; g++) begin : g_shift
        exp2_shift_stage #(
            .SHIFT  (2 ** (INT_W - 1 - g)),
            .SEL_BIT(INT_W - 1 - g)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .i_adv  (w_adv),
            .i_valid(w_valid[g]),
            .i_zero (w_zero[g]),
            .i_sh   (w_sh[g]),
            .i_acc  (w_acc[g]),
            .o_valid(w_valid[g+1]),
            .o_zero (w_zero[g+1]),
            .o_sh   (w_sh[g+1]),
            .o_acc  (w_acc[g+1])
        );
    end

    logic [WORD_W:0] w_int;
    logic [WORD_W:0] w_rnd;
    logic            w_unused;

    assign w_int    = w_acc[INT_W][ACC_W-1:FRAC_W];
    assign w_rnd    = w_int + {{WORD_W{1'b0}}, w_acc[INT_W][FRAC_W-1]};
    assign w_unused = ^{w_sh[INT_W], w_acc[INT_W][FRAC_W-2:0]};

    word_t r_word;
    logic  r_sat;

    // Output word only updates on a valid sample so it keeps its last value across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_sat       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_valid[INT_W];
            if (w_valid[INT_W]) begin
                if (w_zero[INT_W]) begin
                    r_word <= '0;
                    r_sat  <= 1'b0;
                end else if (w_rnd[WORD_W]) begin
                    r_word <= '1;
                    r_sat  <= 1'b1;
                end else begin
                    r_word <= w_rnd[WORD_W-1:0];
                    r_sat  <= 1'b0;
                end
            end
        end
    end

    assign o_VALID = r_out_valid;
    assign o_WORD  = r_word;
    assign o_SAT   = r_sat;
endmodule
